// File: rtl/multicycle_memory_if.sv
// Request/response bus between a CPU initiator and the multicycle data memory.
// The initiator holds enable until it sees data_valid.
interface multicycle_memory_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        busy;
    logic        data_valid;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, busy, data_valid
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, busy, data_valid
    );
endinterface

// File: rtl/multicycle_memory.sv
// Word-organised data memory that takes one request at a time and completes it
// LATENCY cycles after acceptance with a one-cycle data_valid pulse.
module multicycle_memory #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_memory_if.slave  bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_BITS;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 busy_q, busy_nxt;
    logic                 valid_q, valid_nxt;
    logic [DATA_W-1:0]    data_out_q;
    logic                 req_wr;
    logic [ADDR_BITS-1:0] req_idx;
    logic [DATA_W-1:0]    req_data;
    logic                 accept_c;
    logic                 complete_c;
    logic [DATA_W-1:0]    mem [DEPTH];

    // Byte address bit 0 and the bits above the word index are deliberately ignored.
    logic unused_addr_c;
    assign unused_addr_c = &{1'b0, bus.addr};

    // Next-state, counter and acknowledge decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy_nxt   = 1'b0;
        valid_nxt  = 1'b0;
        accept_c   = 1'b0;
        complete_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.enable) begin
                    accept_c  = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    busy_nxt  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt  = cnt - CNT_W'(1);
                    busy_nxt = 1'b1;
                end else begin
                    complete_c = 1'b1;
                    state_nxt  = IDLE;
                    valid_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, request latch and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            req_wr     <= 1'b0;
            req_idx    <= '0;
            req_data   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            busy_q  <= busy_nxt;
            valid_q <= valid_nxt;
            if (accept_c) begin
                req_wr   <= bus.wr;
                req_idx  <= bus.addr[ADDR_BITS:1];
                req_data <= bus.data_in;
            end
            if (complete_c && !req_wr) begin
                data_out_q <= mem[req_idx];
            end
        end
    end

    // Storage array: written only at write completion, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && complete_c && req_wr) begin
            mem[req_idx] <= req_data;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.busy       = busy_q;
    assign bus.data_valid = valid_q;
endmodule

// File: tb/tb_multicycle_memory.sv
// Directed bench for multicycle_memory: default build (LATENCY=4) and a
// LATENCY=1 build sharing clock and reset.
module tb_multicycle_memory;
    logic clk;
    logic rst;
    int   checks;
    int   passed;
    int   fails;

    multicycle_memory_if m4 ();
    multicycle_memory_if m1 ();

    multicycle_memory #(.ADDR_BITS(10), .LATENCY(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (m4.slave)
    );

    multicycle_memory #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (m1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated request on the LATENCY=4 build, checking the full busy/valid timeline.
    task automatic req4(input string tag, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_out);
        m4.enable  = 1'b1;
        m4.wr      = w;
        m4.addr    = a;
        m4.data_in = d;
        tick();
        m4.enable = 1'b0;
        chk({tag, " busy T"}, 16'(m4.busy), 16'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({tag, " busy mid"}, 16'(m4.busy), 16'd1);
            chk({tag, " valid mid"}, 16'(m4.data_valid), 16'd0);
        end
        tick();
        chk({tag, " busy done"}, 16'(m4.busy), 16'd0);
        chk({tag, " valid done"}, 16'(m4.data_valid), 16'd1);
        chk({tag, " data_out"}, m4.data_out, exp_out);
        tick();
        chk({tag, " valid after"}, 16'(m4.data_valid), 16'd0);
    endtask

    initial begin
        int pulses;
        checks = 0;
        passed = 0;
        fails  = 0;
        rst = 1'b1;
        m4.enable = 1'b0; m4.wr = 1'b0; m4.addr = '0; m4.data_in = '0;
        m1.enable = 1'b0; m1.wr = 1'b0; m1.addr = '0; m1.data_in = '0;
        tick();
        tick();
        chk("rst busy", 16'(m4.busy), 16'd0);
        chk("rst valid", 16'(m4.data_valid), 16'd0);
        chk("rst data_out", m4.data_out, 16'h0000);
        rst = 1'b0;
        tick();

        // Write then read at the default latency.
        req4("wr beef", 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        req4("rd beef", 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        // Byte-address bit 0 and bits above the index alias to the same word.
        req4("wr 1234", 1'b1, 16'h0006, 16'h1234, 16'hBEEF);
        req4("rd 0007", 1'b0, 16'h0007, 16'h0000, 16'h1234);
        req4("rd 0806", 1'b0, 16'h0806, 16'h0000, 16'h1234);

        // A write strobed while busy is dropped.
        req4("wr w0", 1'b1, 16'h0000, 16'h0F0F, 16'h1234);
        m4.enable = 1'b1; m4.wr = 1'b0; m4.addr = 16'h0010;
        tick();
        m4.enable = 1'b0;
        tick();
        m4.enable = 1'b1; m4.wr = 1'b1; m4.addr = 16'h0000; m4.data_in = 16'hFFFF;
        tick();
        m4.enable = 1'b0;
        chk("drop busy T+2", 16'(m4.busy), 16'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m4.data_valid) pulses++;
        end
        chk("drop pulse count", 16'(pulses), 16'd1);
        chk("drop data_out", m4.data_out, 16'hBEEF);
        chk("drop busy end", 16'(m4.busy), 16'd0);
        req4("rd w0", 1'b0, 16'h0000, 16'h0000, 16'h0F0F);

        // Held enable: back-to-back reads accepted at T and T+5.
        m4.enable = 1'b1; m4.wr = 1'b0; m4.addr = 16'h0006;
        tick();
        m4.addr = 16'h0010;
        tick(); tick(); tick();
        chk("b2b valid T+3", 16'(m4.data_valid), 16'd0);
        tick();
        chk("b2b valid T+4", 16'(m4.data_valid), 16'd1);
        chk("b2b data1", m4.data_out, 16'h1234);
        chk("b2b busy T+4", 16'(m4.busy), 16'd0);
        tick();
        m4.enable = 1'b0;
        chk("b2b busy T+5", 16'(m4.busy), 16'd1);
        chk("b2b valid T+5", 16'(m4.data_valid), 16'd0);
        tick(); tick(); tick();
        chk("b2b valid T+8", 16'(m4.data_valid), 16'd0);
        tick();
        chk("b2b valid T+9", 16'(m4.data_valid), 16'd1);
        chk("b2b data2", m4.data_out, 16'hBEEF);
        tick();

        // Reset aborts an in-flight write; array contents survive.
        req4("wr 5555", 1'b1, 16'h0020, 16'h5555, 16'hBEEF);
        m4.enable = 1'b1; m4.wr = 1'b1; m4.addr = 16'h0020; m4.data_in = 16'hAAAA;
        tick();
        m4.enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid busy", 16'(m4.busy), 16'd0);
        chk("rstmid valid", 16'(m4.data_valid), 16'd0);
        chk("rstmid data_out", m4.data_out, 16'h0000);
        tick(); tick(); tick();
        chk("rstmid no late valid", 16'(m4.data_valid), 16'd0);
        req4("rd 5555", 1'b0, 16'h0020, 16'h0000, 16'h5555);

        // LATENCY=1 build: completion one edge after acceptance.
        m1.enable = 1'b1; m1.wr = 1'b1; m1.addr = 16'h0002; m1.data_in = 16'h00C3;
        tick();
        m1.enable = 1'b0;
        chk("l1 wr busy", 16'(m1.busy), 16'd1);
        chk("l1 wr valid0", 16'(m1.data_valid), 16'd0);
        tick();
        chk("l1 wr busy done", 16'(m1.busy), 16'd0);
        chk("l1 wr valid", 16'(m1.data_valid), 16'd1);
        chk("l1 wr data_out", m1.data_out, 16'h0000);
        tick();
        chk("l1 valid clear", 16'(m1.data_valid), 16'd0);
        m1.enable = 1'b1; m1.wr = 1'b0; m1.addr = 16'h0002;
        tick();
        m1.enable = 1'b0;
        chk("l1 rd busy", 16'(m1.busy), 16'd1);
        tick();
        chk("l1 rd valid", 16'(m1.data_valid), 16'd1);
        chk("l1 rd data", m1.data_out, 16'h00C3);
        chk("l1 rd busy done", 16'(m1.busy), 16'd0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
